ex_data_rd_sched: RTL and testbench
===================================

Name: ex_data_rd_sched

Overview:
- Read-side scheduler that shares one downstream consumer between N_CH prefetch FIFOs of the ex_data_fifo type.
- Each FIFO exposes rd_data/rd_vld/rd_en. The block grants one channel at a time, round-robin, for bursts of up to BURST_LEN beats.
- It drives that channel's rd_en and presents its words on a single valid/ready output stream tagged with the channel id.
- Sits in the rd_clk domain, between the FIFO bank and the execution-data consumer.

Parameters:
- N_CH, 4, number of FIFO channels, 2..16.
- DATA_W, 32, word width; equals the FIFO c_RD_DATA_WIDTH.
- BURST_LEN, 8, maximum beats per grant, 1..256.
- CH_W, $clog2(N_CH), channel id width. Derived; not overridden.

Ports:
- rd_clk  in  1  clock.
- rd_rst  in  1  reset, asynchronous, active-high.
- ch_rd_data  in  N_CH*DATA_W  flattened FIFO read data; channel i at [i*DATA_W +: DATA_W].
- ch_rd_vld  in  N_CH  per-channel FIFO rd_vld.
- ch_rd_en  out  N_CH  per-channel FIFO rd_en (pop).
- out_data  out  DATA_W  scheduled word.
- out_ch  out  CH_W  channel id of out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  a grant is active.

Behaviour:
- Single clock, rd_clk. Reset is asynchronous, active-high, on rd_rst. All state registers clear on reset.
- Reset values:
  - state=IDLE, grant=0, beat_cnt=0, rr_ptr=N_CH-1, so channel 0 has first priority.
  - Outputs: busy=0, out_valid=0, ch_rd_en=0, out_ch=0.
- Two states, IDLE and BURST.
- IDLE:
  - Search ch_rd_vld starting from (rr_ptr+1) mod N_CH, wrapping.
  - If any bit is set: register grant=first hit, rr_ptr=grant, beat_cnt=0, go to BURST.
  - If none: stay in IDLE.
  - Arbitration latency is 1 cycle; no data moves in the IDLE cycle.
- BURST, combinational outputs:
  - out_valid = ch_rd_vld[grant].
  - out_data = ch_rd_data[grant].
  - out_ch = grant.
  - ch_rd_en[grant] = out_ready & ch_rd_vld[grant]; all other ch_rd_en bits are 0.
  - busy=1.
- BURST handshake:
  - A beat transfers when out_valid & out_ready; this is exactly the FIFO pop.
  - On a beat with beat_cnt==BURST_LEN-1: go to IDLE.
  - On any other beat: beat_cnt+1.
  - beat_cnt is 8 bits wide and never wraps inside a burst.
- Early termination:
  - In BURST, if ch_rd_vld[grant]==0 at a clock edge, go to IDLE. The FIFO bubbled or emptied.
  - No beat is lost, because none transferred in that cycle.
- Stall: out_ready=0 holds the state and beat_cnt. out_data stays stable while out_valid=1 and out_ready=0, because the FIFO holds its head until popped.
- Fairness:
  - rr_ptr updates only on grant.
  - The channel after the last granted one has highest priority in the next IDLE.
  - A continuously-valid channel cannot starve others: the worst-case wait is (N_CH-1)*(BURST_LEN+1) cycles at full ready.
- Simultaneous events: a final beat and a new request in the same cycle still pass through IDLE, giving one dead cycle between bursts. This is required behaviour.
- Only the granted channel's ch_rd_vld is sampled in BURST; requests arriving mid-burst wait.
- Reset mid-burst: the burst is dropped immediately and ch_rd_en is forced to 0. The FIFOs are reset by their own rd_rst in the same domain.

Optional Feature:
- Macro: EX_DATA_RD_SCHED_STAT_EN.
- When defined:
  - Adds output stat_beats, width N_CH*16.
  - Per channel, a 16-bit saturating counter of transferred beats. It stops at 16'hFFFF.
  - Adds input stat_clr, 1 bit. stat_clr=1 synchronously zeroes all counters; if it coincides with a beat, the clear wins.
  - Counters reset to 0.
- When undefined: the stat ports and counters do not exist. Scheduling behaviour is identical.

Decomposition:
- Package ex_data_rd_sched_pkg holds:
  - state enum: IDLE=1'b0, BURST=1'b1.
  - BEAT_CNT_W=8.
  - STAT_W=16.
- Sub-module ex_data_rr_pick: combinational round-robin first-hit finder.
  - Inputs: req[N_CH], ptr[CH_W].
  - Outputs: hit, idx[CH_W].
  - Reused by other arbiters in the design.

Test Plan:
1. Reset, then only ch0 valid with 20 words queued, out_ready=1, BURST_LEN=8.
   - Bursts of 8, 8, 4 beats.
   - One idle cycle between bursts.
   - out_ch=0 throughout; data order preserved.
2. All 4 channels continuously valid, out_ready=1.
   - Grant sequence 0,1,2,3,0, each 8 beats.
   - Each beat pops only the granted channel.
3. ch2 valid for 3 words, then drops.
   - Burst terminates after 3 beats; state=IDLE next cycle.
   - rr_ptr=2, so next priority goes to ch3.
4. out_ready toggles 1,0,0,1 mid-burst.
   - ch_rd_en=0 and out_data stable during stalls.
   - Beat count stays exact: a total of 8 beats before release.
5. rd_rst asserted for 1 cycle at beat 4 of a burst.
   - Outputs are 0 asynchronously.
   - After release, ch0 is picked first.
6. With EX_DATA_RD_SCHED_STAT_EN: 70000 beats on ch1.
   - stat_beats[31:16]=16'hFFFF (saturated).
   - stat_clr pulse gives 0 on the next cycle.

Source files
------------

// File: rtl/ex_data_rd_sched_pkg.sv
// ex_data_rd_sched_pkg: shared types and widths for the read-side scheduler.
// Optional statistics are enabled by defining EX_DATA_RD_SCHED_STAT_EN.
package ex_data_rd_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int BEAT_CNT_W = 8;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/ex_data_rd_sched_if.sv
// ex_data_rd_sched_if: scheduled output stream (valid/ready, channel-tagged).
// master drives data/ch/valid; slave returns ready.
interface ex_data_rd_sched_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32
);
  import ex_data_rd_sched_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/ex_data_rr_pick.sv
// ex_data_rr_pick: combinational round-robin first-hit finder.
// Searches req starting at (ptr+1) mod N_CH, wrapping.
module ex_data_rr_pick
  import ex_data_rd_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            hit,
  output logic [CH_W-1:0] idx
);

  int unsigned c;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    c   = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      c = (32'(ptr) + k) % N_CH;
      if (!hit && req[c[CH_W-1:0]]) begin
        hit = 1'b1;
        idx = c[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ex_data_rd_sched.sv
// ex_data_rd_sched: round-robin burst scheduler over N_CH prefetch FIFOs.
// EX_DATA_RD_SCHED_STAT_EN adds per-channel saturating beat counters.
module ex_data_rd_sched
  import ex_data_rd_sched_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic [N_CH*DATA_W-1:0] ch_rd_data,
  input  logic [N_CH-1:0]        ch_rd_vld,
  output logic [N_CH-1:0]        ch_rd_en,
  ex_data_rd_sched_if.master     ob,
`ifdef EX_DATA_RD_SCHED_STAT_EN
  input  logic                   stat_clr,
  output logic [N_CH*STAT_W-1:0] stat_beats,
`endif
  output logic                   busy
);

  localparam logic [BEAT_CNT_W-1:0] LAST =
    BEAT_CNT_W'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic            pick_hit;
  logic [CH_W-1:0] pick_idx;
  logic            burst;
  logic            vld_g;
  logic            beat;

  ex_data_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req (ch_rd_vld),
    .ptr (rr_ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign burst = (state_q == BURST);
  assign vld_g = ch_rd_vld[grant_q];
  assign beat  = burst & vld_g & ob.out_ready;

  assign busy         = burst;
  assign ob.out_valid = burst & vld_g;
  assign ob.out_ch    = burst ? grant_q : '0;
  assign ob.out_data  = burst
    ? ch_rd_data[32'(grant_q)*DATA_W +: DATA_W]
    : '0;

  always_comb begin
    ch_rd_en = '0;
    if (burst) begin
      ch_rd_en[grant_q] = ob.out_ready & vld_g;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d    = pick_idx;
          rr_ptr_d   = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // a bubble ends the burst; nothing moved this cycle
        if (!vld_g) begin
          state_d = IDLE;
        end else if (ob.out_ready) begin
          if (beat_cnt_q == LAST) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= CH_W'(N_CH - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef EX_DATA_RD_SCHED_STAT_EN
  logic [STAT_W-1:0] stat_q [N_CH];
  logic [STAT_W-1:0] stat_d [N_CH];

  // clear has priority over a coincident beat
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (beat && grant_q == CH_W'(i) && stat_q[i] != '1) begin
        stat_d[i] = stat_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < N_CH; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_stat
    assign stat_beats[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_ex_data_rd_sched.sv
// tb_ex_data_rd_sched: directed stimulus with FIFO models and a scoreboard
// monitor checking every beat, burst lengths, stalls and reset behaviour.
module tb_ex_data_rd_sched;
  import ex_data_rd_sched_pkg::*;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int BL     = 8;

  logic                   rd_clk = 1'b0;
  logic                   rd_rst = 1'b1;
  logic [N_CH*DATA_W-1:0] ch_rd_data;
  logic [N_CH-1:0]        ch_rd_vld;
  logic [N_CH-1:0]        ch_rd_en;
  logic                   busy;
`ifdef EX_DATA_RD_SCHED_STAT_EN
  logic                   stat_clr = 1'b0;
  logic [N_CH*STAT_W-1:0] stat_beats;
`endif

  ex_data_rd_sched_if #(.N_CH(N_CH), .DATA_W(DATA_W)) ob ();

  ex_data_rd_sched #(
    .N_CH      (N_CH),
    .DATA_W    (DATA_W),
    .BURST_LEN (BL)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .ch_rd_data (ch_rd_data),
    .ch_rd_vld  (ch_rd_vld),
    .ch_rd_en   (ch_rd_en),
    .ob         (ob),
`ifdef EX_DATA_RD_SCHED_STAT_EN
    .stat_clr   (stat_clr),
    .stat_beats (stat_beats),
`endif
    .busy       (busy)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_len[$];
  logic [31:0] fq [N_CH][$];
  logic [N_CH-1:0] pend = '0;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  int run   = 0;
  logic        stall_p = 1'b0;
  logic [31:0] stall_d = '0;
  exp_t        e;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N_CH; i++) begin
      ch_rd_vld[i] = (fq[i].size() > 0);
      ch_rd_data[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(int c, int n, logic [31:0] base);
    for (int k = 0; k < n; k++) fq[c].push_back(base + 32'(k));
    refresh();
  endtask

  task automatic expect_w(int c, int n, logic [31:0] base);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{ch: 2'(c), d: base + 32'(k)});
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N_CH; i++) fq[i].delete();
    refresh();
  endtask

  task automatic do_reset();
    @(posedge rd_clk); #2;
    rd_rst = 1'b1;
    clear_fifos();
    repeat (2) @(posedge rd_clk);
    #2 rd_rst = 1'b0;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 2000) begin
      @(posedge rd_clk);
      n++;
    end
    repeat (2) @(posedge rd_clk);
    #2;
    chk({"drain_", nm}, 64'(n < 2000), 64'd1);
  endtask

  // FIFO pop: rd_en captured mid-cycle, applied just after the edge
  always @(negedge rd_clk) pend = ch_rd_en;

  always @(posedge rd_clk) begin
    #1;
    for (int i = 0; i < N_CH; i++)
      if (pend[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    pend = '0;
    refresh();
  end

  always @(negedge rd_clk) begin
    if (!rd_rst) begin
      if (ob.out_valid && ob.out_ready) begin
        beats++;
        run++;
        chk("rd_en_onehot", 64'(ch_rd_en), 64'(1) << ob.out_ch);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat act=%0d/%0h req=none",
                   ob.out_ch, ob.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_ch", 64'(ob.out_ch), 64'(e.ch));
          chk("beat_data", 64'(ob.out_data), 64'(e.d));
        end
      end
      if (stall_p && ob.out_valid)
        chk("stall_data", 64'(ob.out_data), 64'(stall_d));
      stall_p = ob.out_valid && !ob.out_ready;
      if (stall_p) begin
        stall_d = ob.out_data;
        chk("stall_rd_en", 64'(ch_rd_en), 64'd0);
      end
      if (!busy && run > 0) begin
        if (exp_len.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_burst act=%0d req=none", run);
        end else begin
          chk("burst_len", 64'(run), 64'(exp_len.pop_front()));
        end
        run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    logic [3:0] pat;
    pat = 4'b1001;
    ob.out_ready = 1'b1;
    clear_fifos();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(ob.out_valid), 64'd0);
    chk("rst_rd_en", 64'(ch_rd_en), 64'd0);
    chk("rst_out_ch", 64'(ob.out_ch), 64'd0);
    repeat (2) @(posedge rd_clk);
    #2 rd_rst = 1'b0;

    // 1: single channel, 20 words -> bursts 8,8,4
    load(0, 20, 32'h100);
    expect_w(0, 20, 32'h100);
    exp_len.push_back(8);
    exp_len.push_back(8);
    exp_len.push_back(4);
    drain("t1");

    // 2: all channels valid -> grants 0,1,2,3,0
    do_reset();
    load(0, 16, 32'h2000);
    load(1, 8, 32'h2100);
    load(2, 8, 32'h2200);
    load(3, 8, 32'h2300);
    expect_w(0, 8, 32'h2000);
    expect_w(1, 8, 32'h2100);
    expect_w(2, 8, 32'h2200);
    expect_w(3, 8, 32'h2300);
    expect_w(0, 8, 32'h2008);
    repeat (5) exp_len.push_back(8);
    drain("t2");

    // 3: ch2 runs dry after 3; then ch3 outranks ch1
    load(2, 3, 32'h3200);
    expect_w(2, 3, 32'h3200);
    exp_len.push_back(3);
    drain("t3a");
    load(1, 2, 32'h3100);
    load(3, 2, 32'h3300);
    expect_w(3, 2, 32'h3300);
    expect_w(1, 2, 32'h3100);
    exp_len.push_back(2);
    exp_len.push_back(2);
    drain("t3b");

    // 4: ready pattern 1,0,0,1 during a burst
    load(0, 8, 32'h4000);
    expect_w(0, 8, 32'h4000);
    exp_len.push_back(8);
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 200) begin
      @(posedge rd_clk); #2;
      ob.out_ready = pat[n % 4];
      n++;
    end
    ob.out_ready = 1'b1;
    drain("t4");

    // 5: reset after four beats of a ch2 burst
    load(2, 8, 32'h5200);
    expect_w(2, 4, 32'h5200);
    exp_len.push_back(4);
    b0 = beats;
    n  = 0;
    while (beats < b0 + 4 && n < 200) begin
      @(negedge rd_clk); #1;
      n++;
    end
    chk("t5_reach_beat4", 64'(n < 200), 64'd1);
    @(posedge rd_clk); #1;
    rd_rst = 1'b1;
    #1;
    clear_fifos();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(ob.out_valid), 64'd0);
    chk("t5_rd_en", 64'(ch_rd_en), 64'd0);
    chk("t5_out_ch", 64'(ob.out_ch), 64'd0);
    @(posedge rd_clk); #2;
    rd_rst = 1'b0;
    load(0, 2, 32'h5000);
    load(1, 2, 32'h5100);
    load(3, 2, 32'h5300);
    expect_w(0, 2, 32'h5000);
    expect_w(1, 2, 32'h5100);
    expect_w(3, 2, 32'h5300);
    repeat (3) exp_len.push_back(2);
    drain("t5");

`ifdef EX_DATA_RD_SCHED_STAT_EN
    chk("stat_ch0", 64'(stat_beats[15:0]), 64'd2);
    chk("stat_ch2", 64'(stat_beats[47:32]), 64'd0);
    stat_clr = 1'b1;
    @(posedge rd_clk); #2;
    stat_clr = 1'b0;
    chk("stat_clr", 64'(stat_beats), 64'd0);
`endif

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("exp_len_empty", 64'(exp_len.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
